dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-ported 64-bit data memory (1024 doublewords, byte-addressed, 0x0000–0x1FF8) between two requesters: the core's memory stage (port C) and the program loader/debug port (port L).
- Request/grant handshake per requester; round-robin arbitration; 3-state sequencer that drives the memory port and returns read data with a one-cycle `rvalid` pulse.
- Performs bounds and alignment checking, so illegal accesses never reach the memory.

Parameters:
- DATA_W, 64, data width in bits
- ADDR_W, 64, byte-address width
- DEPTH, 1024, memory depth in doublewords; legal byte range is 0 .. DEPTH*8-8

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- c_req  in  1  core request; held until c_gnt is seen
- c_we  in  1  core write (1) / read (0)
- c_addr  in  ADDR_W  core byte address
- c_wdata  in  DATA_W  core write data
- c_gnt  out  1  one-cycle pulse: core request accepted
- c_rvalid  out  1  one-cycle pulse: core transaction complete
- c_rdata  out  DATA_W  core read data, valid with c_rvalid
- c_err  out  1  with c_rvalid: out-of-bounds or misaligned access
- l_req, l_we, l_addr, l_wdata, l_gnt, l_rvalid, l_rdata, l_err: loader port, identical to the core set
- m_re  out  1  memory read enable
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory byte address
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory read data, valid in the same cycle m_re is high

Behaviour:
- Reset (async, immediate): state=IDLE, rr_last=L (so the core wins the first tie). All outputs are 0, including the latched address, data, rdata and err. Any in-flight transaction is dropped: no rvalid, and m_we falls immediately.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE. One transaction per 3 cycles.
- IDLE: at a clock edge with any req high, select a winner and latch its we/addr/wdata/id. Go to ACCESS.
  - Winner when only one requests: that requester.
  - Winner when both request: the requester not in rr_last. Update rr_last to the winner.
  - No request: stay in IDLE.
- ACCESS (1 cycle):
  - The winner's gnt is high for exactly this cycle.
  - Legal access (addr < DEPTH*8 and addr[2:0]==0): drive m_addr/m_wdata from the latch; m_re=!we, m_we=we.
  - Illegal access: m_re=m_we=0; set err_latch=1.
  - For legal reads, capture m_rdata into rdata_latch at the end of the cycle. Go to RESP.
- RESP (1 cycle):
  - Winner's rvalid=1, rdata=rdata_latch, err=err_latch.
  - rdata is 0 for writes and for errored accesses.
  - Non-winner rvalid/err stay 0. Go to IDLE.
- Outputs are registered or decoded from state only; no combinational path from req to gnt or to m_*.
- Dropping req after the sampling edge does not cancel the transaction; it completes and rvalid still pulses.
- Latency: req sampled at edge N -> gnt and memory access in cycle N+1 -> rvalid in cycle N+2.
- Starvation bound: a continuously requesting port waits at most one foreign transaction.
- Read-after-write to the same address from either port returns the written data.

Optional Feature:
- Macro: DMEM_ARB_CORE_PRIO_EN.
- Defined: fixed priority. The core always wins a tie; rr_last is not implemented; the loader may starve under back-to-back core traffic.
- Undefined (default): round-robin as described above.

Decomposition:
- Shared package `riscv_pkg`:
  - state enum `dmem_arb_state_t` {IDLE, ACCESS, RESP}
  - requester id constants REQ_CORE=0, REQ_LOAD=1
  - constant DMEM_BYTES = DEPTH*8
- One sub-module, `rr_arb2`: combinational 2-way pick taking (req[1:0], last) and returning a winner id. Include it only when DMEM_ARB_CORE_PRIO_EN is undefined.

Test Plan:
- Core write 0x10 = 0xDEADBEEFDEADBEEF, then core read 0x10:
  - c_gnt 1 cycle after each request.
  - c_rvalid 2 cycles after each request.
  - Read returns c_rdata=0xDEADBEEFDEADBEEF, c_err=0.
- Both ports request on the same edge (core read 0x20, loader write 0x20 = 0x1234567890ABCDEF):
  - Core wins first, c_rdata=0.
  - Loader granted next.
  - A following core read of 0x20 returns 0x1234567890ABCDEF.
- Both ports hold req continuously for 6 transactions:
  - Grants alternate C,L,C,L,C,L.
  - With DMEM_ARB_CORE_PRIO_EN defined: all six grants go to C.
- Boundaries:
  - Loader write then read at 0x1FF8 returns 0x5555555555555555, l_err=0.
  - Read at 0x2000: l_err=1, l_rdata=0, m_re never asserted.
  - Read at 0x0C: err=1 (misaligned).
- Assert reset during ACCESS of a core write to 0x10:
  - m_we drops immediately; all outputs are 0.
  - No c_rvalid is issued.
  - FSM restarts in IDLE, and the next tie goes to the core.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the data-memory arbiter: sequencer states,
// requester ids and the default memory size.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } dmem_arb_state_t;

  // Requester ids double as bit positions in the per-port request/grant vectors.
  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_LOAD = 1'b1;

  // Default data memory: 1024 doublewords.
  localparam int DMEM_DEPTH = 1024;
  localparam int DMEM_BYTES = DMEM_DEPTH * 8;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports (core C, loader L) and the memory port.
// slave: the arbiter's view. master: the requesters' and memory's view.
interface dmem_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
);
  logic              c_req, c_we, c_gnt, c_rvalid, c_err;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata, c_rdata;

  logic              l_req, l_we, l_gnt, l_rvalid, l_err;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata, l_rdata;

  logic              m_re, m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata, m_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    output c_gnt, c_rvalid, c_rdata, c_err,
    input  l_req, l_we, l_addr, l_wdata,
    output l_gnt, l_rvalid, l_rdata, l_err,
    output m_re, m_we, m_addr, m_wdata,
    input  m_rdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    input  c_gnt, c_rvalid, c_rdata, c_err,
    output l_req, l_we, l_addr, l_wdata,
    input  l_gnt, l_rvalid, l_rdata, l_err,
    input  m_re, m_we, m_addr, m_wdata,
    output m_rdata
  );
endinterface

// File: rtl/dmem_arbiter_rr.sv
// rr_arb2: combinational two-way round-robin pick. On a tie the requester
// that did not win the previous tie is chosen; a lone requester always wins.
module rr_arb2
  import riscv_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       win
);

  // Tie goes to the port not named in last; otherwise the only requester.
  always_comb begin
    win = REQ_CORE;
    if (req == 2'b11)       win = ~last;
    else if (req[REQ_LOAD]) win = REQ_LOAD;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data memory between the core memory
// stage (C) and the loader/debug port (L). IDLE -> ACCESS -> RESP sequencer,
// one transaction per three cycles, with bounds/alignment checking so illegal
// accesses never reach the memory.
// Build option DMEM_ARB_CORE_PRIO_EN: fixed core priority instead of
// round-robin (the loader can starve under back-to-back core traffic).
module dmem_arbiter
  import riscv_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64,
  parameter int DEPTH  = DMEM_BYTES / 8
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH * 8);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  dmem_arb_state_t   state_q, state_d;
  logic [1:0]        req;
  req_t              c_cand, l_cand, pick, lat_q;
  logic              win, id_q, err_q, legal;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        gnt, rvalid;
  logic              m_re, m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;

  assign req    = {bus.l_req, bus.c_req};
  assign c_cand = {bus.c_we, bus.c_addr, bus.c_wdata};
  assign l_cand = {bus.l_we, bus.l_addr, bus.l_wdata};
  assign pick   = (win == REQ_LOAD) ? l_cand : c_cand;

  // Checked against the latched request only, so nothing from req reaches m_*.
  assign legal = (lat_q.addr < LIMIT) && (lat_q.addr[2:0] == 3'b000);

`ifdef DMEM_ARB_CORE_PRIO_EN
  assign win = req[REQ_CORE] ? REQ_CORE : REQ_LOAD;
`else
  logic rr_last_q;

  rr_arb2 u_rr (
    .req  (req),
    .last (rr_last_q),
    .win  (win)
  );

  // Remember the winner of each tie; reset favours the core on the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         rr_last_q <= REQ_LOAD;
    else if (state_q == IDLE && &req)  rr_last_q <= win;
  end
`endif

  // Sequencer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state plus grant/rvalid/memory-port decode from state and latch.
  always_comb begin
    state_d = state_q;
    gnt     = '0;
    rvalid  = '0;
    m_re    = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    case (state_q)
      IDLE: if (|req) state_d = ACCESS;
      ACCESS: begin
        state_d  = RESP;
        gnt[id_q] = 1'b1;
        if (legal) begin
          m_re    = ~lat_q.we;
          m_we    = lat_q.we;
          m_addr  = lat_q.addr;
          m_wdata = lat_q.wdata;
        end
      end
      RESP: begin
        state_d     = IDLE;
        rvalid[id_q] = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Latch the winning request in IDLE; capture error and read data in ACCESS.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_q   <= '0;
      id_q    <= REQ_CORE;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (|req) begin
          lat_q   <= pick;
          id_q    <= win;
          err_q   <= 1'b0;
          rdata_q <= '0;
        end
        ACCESS: begin
          err_q <= ~legal;
          if (legal && !lat_q.we) rdata_q <= bus.m_rdata;
        end
        default: ;
      endcase
    end
  end

  assign bus.m_re    = m_re;
  assign bus.m_we    = m_we;
  assign bus.m_addr  = m_addr;
  assign bus.m_wdata = m_wdata;

  assign bus.c_gnt    = gnt[REQ_CORE];
  assign bus.c_rvalid = rvalid[REQ_CORE];
  assign bus.c_rdata  = rvalid[REQ_CORE] ? rdata_q : '0;
  assign bus.c_err    = rvalid[REQ_CORE] & err_q;

  assign bus.l_gnt    = gnt[REQ_LOAD];
  assign bus.l_rvalid = rvalid[REQ_LOAD];
  assign bus.l_rdata  = rvalid[REQ_LOAD] ? rdata_q : '0;
  assign bus.l_err    = rvalid[REQ_LOAD] & err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural memory, per-port response scoreboards
// filled when requests are issued and drained on rvalid.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_W(64), .ADDR_W(64)) bus ();

  dmem_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [63:0] mem [0:1023];
  assign bus.m_rdata = mem[bus.m_addr[12:3]];
  always @(posedge clk) if (bus.m_we) mem[bus.m_addr[12:3]] <= bus.m_wdata;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  exp_t qc[$];
  exp_t ql[$];
  int vectors = 0;
  int fails   = 0;
  int mre_cnt = 0;
  int rv_cnt  = 0;

  // Advance to the next falling edge and drain any response into the scoreboard.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (bus.m_re) mre_cnt++;
    if (bus.c_rvalid) rv_cnt++;
    if (bus.l_rvalid) rv_cnt++;
    if (bus.c_rvalid) begin
      vectors++;
      if (qc.size() == 0) begin
        fails++;
        $display("FAIL c_unexpected_rvalid rdata=%h err=%b", bus.c_rdata, bus.c_err);
      end else begin
        e = qc.pop_front();
        if ({bus.c_rdata, bus.c_err} !== {e.rdata, e.err}) begin
          fails++;
          $display("FAIL c_resp got rdata=%h err=%b want rdata=%h err=%b",
                   bus.c_rdata, bus.c_err, e.rdata, e.err);
        end
      end
    end
    if (bus.l_rvalid) begin
      vectors++;
      if (ql.size() == 0) begin
        fails++;
        $display("FAIL l_unexpected_rvalid rdata=%h err=%b", bus.l_rdata, bus.l_err);
      end else begin
        e = ql.pop_front();
        if ({bus.l_rdata, bus.l_err} !== {e.rdata, e.err}) begin
          fails++;
          $display("FAIL l_resp got rdata=%h err=%b want rdata=%h err=%b",
                   bus.l_rdata, bus.l_err, e.rdata, e.err);
        end
      end
    end
  endtask

  task automatic set_req(input bit p, input bit r, input bit we,
                         input logic [63:0] a, input logic [63:0] d);
    if (p) begin
      bus.l_req = r; bus.l_we = we; bus.l_addr = a; bus.l_wdata = d;
    end else begin
      bus.c_req = r; bus.c_we = we; bus.c_addr = a; bus.c_wdata = d;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bus.c_req = 1'b0;
    bus.l_req = 1'b0;
    qc.delete();
    ql.delete();
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Single-port transaction from IDLE; checks grant and rvalid latency.
  task automatic txn(input bit p, input bit we, input logic [63:0] a,
                     input logic [63:0] d, input logic [63:0] er, input bit ee,
                     input string tag);
    int   cyc;
    exp_t e;
    e.rdata = er;
    e.err   = ee;
    if (p) ql.push_back(e); else qc.push_back(e);
    set_req(p, 1'b1, we, a, d);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!(p ? bus.l_gnt : bus.c_gnt) && cyc < 20);
    vectors++;
    if (cyc != 1) begin
      fails++;
      $display("FAIL %s_gnt_latency got %0d cycles want 1", tag, cyc);
    end
    set_req(p, 1'b0, we, a, d);
    tick();
    vectors++;
    if ((p ? bus.l_rvalid : bus.c_rvalid) !== 1'b1) begin
      fails++;
      $display("FAIL %s_rvalid_latency got rvalid=%b want 1", tag,
               p ? bus.l_rvalid : bus.c_rvalid);
    end
    tick();
  endtask

  // Both ports request on the same edge; reports the cycle each was granted.
  task automatic drive_pair(input bit cwe, input logic [63:0] ca, input logic [63:0] cd,
                            input logic [63:0] cer, input bit cee,
                            input bit lwe, input logic [63:0] la, input logic [63:0] ld,
                            input logic [63:0] ler, input bit lee,
                            output int cg, output int lg);
    int   cyc;
    exp_t e;
    e.rdata = cer; e.err = cee; qc.push_back(e);
    e.rdata = ler; e.err = lee; ql.push_back(e);
    set_req(1'b0, 1'b1, cwe, ca, cd);
    set_req(1'b1, 1'b1, lwe, la, ld);
    cg = 0; lg = 0; cyc = 0;
    while ((cg == 0 || lg == 0) && cyc < 30) begin
      tick();
      cyc++;
      if (bus.c_gnt) begin cg = cyc; bus.c_req = 1'b0; end
      if (bus.l_gnt) begin lg = cyc; bus.l_req = 1'b0; end
    end
    bus.c_req = 1'b0;
    bus.l_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    set_req(1'b1, 1'b0, 1'b0, 64'h0, 64'h0);
    tick();
    vectors++;
    if ({bus.c_gnt, bus.c_rvalid, bus.c_rdata, bus.c_err, bus.l_gnt, bus.l_rvalid,
         bus.l_rdata, bus.l_err, bus.m_re, bus.m_we, bus.m_addr, bus.m_wdata} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got c_gnt=%b l_gnt=%b m_re=%b m_we=%b m_addr=%h want all 0",
               bus.c_gnt, bus.l_gnt, bus.m_re, bus.m_we, bus.m_addr);
    end
    reset = 1'b0;
    tick();
    tick();
    vectors++;
    if ({bus.c_gnt, bus.l_gnt, bus.m_re, bus.m_we, bus.c_rvalid, bus.l_rvalid} !== 6'b0) begin
      fails++;
      $display("FAIL idle_quiet got gnt=%b%b m=%b%b want 0", bus.c_gnt, bus.l_gnt,
               bus.m_re, bus.m_we);
    end
  endtask

  task automatic test_core_rw();
    txn(1'b0, 1'b1, 64'h10, 64'hDEADBEEFDEADBEEF, 64'h0, 1'b0, "core_wr");
    txn(1'b0, 1'b0, 64'h10, 64'h0, 64'hDEADBEEFDEADBEEF, 1'b0, "core_rd");
  endtask

  task automatic test_tie();
    int cg, lg;
    apply_reset();
    drive_pair(1'b0, 64'h20, 64'h0, 64'h0, 1'b0,
               1'b1, 64'h20, 64'h1234567890ABCDEF, 64'h0, 1'b0, cg, lg);
    vectors++;
    if (cg != 1 || lg != 4) begin
      fails++;
      $display("FAIL tie_order got core_cycle=%0d load_cycle=%0d want 1 and 4", cg, lg);
    end
    txn(1'b0, 1'b0, 64'h20, 64'h0, 64'h1234567890ABCDEF, 1'b0, "tie_readback");
  endtask

  task automatic test_back_to_back();
    int   seq [6];
    int   n, cyc, want;
    exp_t e;
    apply_reset();
    txn(1'b0, 1'b1, 64'h40, 64'hC0C0C0C0C0C0C0C0, 64'h0, 1'b0, "b2b_cwr");
    txn(1'b1, 1'b1, 64'h48, 64'h1A1A1A1A1A1A1A1A, 64'h0, 1'b0, "b2b_lwr");
    for (int i = 0; i < 6; i++) seq[i] = -1;
    set_req(1'b0, 1'b1, 1'b0, 64'h40, 64'h0);
    set_req(1'b1, 1'b1, 1'b0, 64'h48, 64'h0);
    n = 0; cyc = 0;
    while (n < 6 && cyc < 60) begin
      tick();
      cyc++;
      if (bus.c_gnt) begin
        e.rdata = 64'hC0C0C0C0C0C0C0C0; e.err = 1'b0; qc.push_back(e);
        seq[n] = 0; n++;
      end else if (bus.l_gnt) begin
        e.rdata = 64'h1A1A1A1A1A1A1A1A; e.err = 1'b0; ql.push_back(e);
        seq[n] = 1; n++;
      end
    end
    bus.c_req = 1'b0;
    bus.l_req = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 6; i++) begin
`ifdef DMEM_ARB_CORE_PRIO_EN
      want = 0;
`else
      want = i % 2;
`endif
      vectors++;
      if (seq[i] != want) begin
        fails++;
        $display("FAIL b2b_grant%0d got %0d want %0d (0=core 1=loader)", i, seq[i], want);
      end
    end
  endtask

  task automatic test_bounds();
    int m0;
    txn(1'b1, 1'b1, 64'h1FF8, 64'h5555555555555555, 64'h0, 1'b0, "top_wr");
    txn(1'b1, 1'b0, 64'h1FF8, 64'h0, 64'h5555555555555555, 1'b0, "top_rd");
    m0 = mre_cnt;
    txn(1'b1, 1'b0, 64'h2000, 64'h0, 64'h0, 1'b1, "oob_rd");
    vectors++;
    if (mre_cnt != m0) begin
      fails++;
      $display("FAIL oob_m_re got %0d pulses want 0", mre_cnt - m0);
    end
    m0 = mre_cnt;
    txn(1'b0, 1'b0, 64'h0C, 64'h0, 64'h0, 1'b1, "misalign_rd");
    vectors++;
    if (mre_cnt != m0) begin
      fails++;
      $display("FAIL misalign_m_re got %0d pulses want 0", mre_cnt - m0);
    end
  endtask

  task automatic test_reset_access();
    int cg, lg, r0;
    set_req(1'b0, 1'b1, 1'b1, 64'h10, 64'hAAAAAAAAAAAAAAAA);
    tick();
    vectors++;
    if ({bus.c_gnt, bus.m_we} !== 2'b11) begin
      fails++;
      $display("FAIL rst_pre_access got c_gnt=%b m_we=%b want 1 1", bus.c_gnt, bus.m_we);
    end
    #1 reset = 1'b1;
    #1;
    vectors++;
    if ({bus.c_gnt, bus.c_rvalid, bus.c_rdata, bus.c_err, bus.l_gnt, bus.l_rvalid,
         bus.l_rdata, bus.l_err, bus.m_re, bus.m_we, bus.m_addr, bus.m_wdata} !== '0) begin
      fails++;
      $display("FAIL rst_mid_outputs got c_gnt=%b m_we=%b m_addr=%h m_wdata=%h want all 0",
               bus.c_gnt, bus.m_we, bus.m_addr, bus.m_wdata);
    end
    bus.c_req = 1'b0;
    tick();
    tick();
    vectors++;
    if (mem[2] !== 64'hDEADBEEFDEADBEEF) begin
      fails++;
      $display("FAIL rst_write_dropped got mem[0x10]=%h want deadbeefdeadbeef", mem[2]);
    end
    reset = 1'b0;
    r0 = rv_cnt;
    for (int i = 0; i < 4; i++) tick();
    vectors++;
    if (rv_cnt != r0) begin
      fails++;
      $display("FAIL rst_no_rvalid got %0d pulses want 0", rv_cnt - r0);
    end
    drive_pair(1'b0, 64'h10, 64'h0, 64'hDEADBEEFDEADBEEF, 1'b0,
               1'b0, 64'h1FF8, 64'h0, 64'h5555555555555555, 1'b0, cg, lg);
    vectors++;
    if (cg != 1 || lg != 4) begin
      fails++;
      $display("FAIL rst_tie_order got core_cycle=%0d load_cycle=%0d want 1 and 4", cg, lg);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 64'h0;
    test_reset();
    test_core_rw();
    test_tie();
    test_back_to_back();
    test_bounds();
    test_reset_access();
    vectors++;
    if (qc.size() != 0 || ql.size() != 0) begin
      fails++;
      $display("FAIL pending_responses got core=%0d loader=%0d want 0", qc.size(), ql.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
